// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch stage. Owns the PC, issues one word read at
//               a time to instruction memory, buffers returned words with
//               their PCs in a small FIFO and hands {inst, pc} to decode.
//               Supports redirect with flush and a sticky halt.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               imem_req_*          - fetch request (valid/ready, addr)
//               imem_rsp_*          - fetch response (valid, data)
//               inst_valid/ready    - decode handshake, inst / inst_pc payload
//               redirect_valid/pc   - load new PC and flush
//               halt                - stop fetching until reset
//               busy                - request outstanding or FIFO non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_req_pc;
    logic               r_drop;
    logic               r_halted;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_mem_inst [FIFO_DEPTH];
    logic [31:0]        r_mem_pc   [FIFO_DEPTH];

    logic               w_outstanding;
    logic [CNT_W-1:0]   w_inflight;
    logic               w_req_fire;
    logic               w_rsp_take;
    logic               w_push;
    logic               w_pop;
    logic               w_halted_nxt;

    // Exactly one request can be in flight, and only while waiting for it.
    assign w_outstanding = (r_state == ST_WAIT);
    assign w_inflight    = r_count + CNT_W'(w_outstanding);
    assign w_halted_nxt  = r_halted | halt;

    // Throttling on count+outstanding guarantees every response has a slot.
    // Gated by rst_n so nothing is requested while reset is held.
    assign imem_req_valid = rst_n && (r_state == ST_REQ) && !r_halted &&
                            (w_inflight < CNT_W'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Responses without an outstanding request are simply ignored.
    assign w_rsp_take = w_outstanding && imem_rsp_valid;
    assign w_push     = w_rsp_take && !r_drop && !redirect_valid;
    assign w_pop      = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid = (r_count != '0);
    assign inst       = inst_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;
    assign busy       = w_outstanding || inst_valid;

    // Control state, PC and FIFO pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= 32'h0;
            r_drop   <= 1'b0;
            r_halted <= 1'b0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (halt) begin
                r_halted <= 1'b1;
            end

            case (r_state)
                ST_REQ: begin
                    if (w_req_fire) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= ST_WAIT;
                    end else if (w_halted_nxt) begin
                        // An unaccepted request is withdrawn on halt.
                        r_state <= ST_HALTED;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_drop  <= 1'b0;
                        r_state <= w_halted_nxt ? ST_HALTED : ST_REQ;
                    end
                end
                ST_HALTED: begin
                    // Only reset leaves this state.
                end
                default: begin
                    r_state <= ST_REQ;
                end
            endcase

            // Redirect overrides the normal PC/state update above.
            if (redirect_valid) begin
                r_pc <= redirect_pc & 32'hFFFF_FFFC;
                if (w_req_fire || (w_outstanding && !imem_rsp_valid)) begin
                    // The reply to a stale request is still to come; eat it.
                    r_drop  <= 1'b1;
                    r_state <= ST_WAIT;
                end else begin
                    // A response arriving now is discarded by the flush,
                    // so there is nothing left to drop.
                    r_drop  <= 1'b0;
                    r_state <= w_halted_nxt ? ST_HALTED : ST_REQ;
                end
            end

            if (redirect_valid) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rsp_data;
            r_mem_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch. Cycle-by-cycle vector
//               table of inputs and hand-computed outputs, followed by a
//               free-running fetch sequence against a one-cycle memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cur_row  = -1;

    always #5 clk = ~clk;

    ifu_fetch #(
        .RESET_PC   (32'h8000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .busy           (busy)
    );

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        rdv;
        logic [31:0] rpc;
        logic        hlt;
        logic        qv;
        logic [31:0] qa;
        logic        iv;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic a_rst, input logic a_rdy, input logic a_rv,
        input logic [31:0] a_rd, input logic a_ir, input logic a_rdv,
        input logic [31:0] a_rpc, input logic a_hlt,
        input logic e_qv, input logic [31:0] e_qa, input logic e_iv,
        input logic [31:0] e_ins, input logic [31:0] e_ipc, input logic e_bsy);
        vec_t v;
        v.rst_n = a_rst; v.rdy = a_rdy; v.rv = a_rv; v.rd = a_rd;
        v.ir = a_ir; v.rdv = a_rdv; v.rpc = a_rpc; v.hlt = a_hlt;
        v.qv = e_qv; v.qa = e_qa; v.iv = e_iv; v.ins = e_ins;
        v.ipc = e_ipc; v.bsy = e_bsy;
        return v;
    endfunction

    function automatic logic [31:0] dw(input int k);
        return 32'hC0DE_0000 + 32'(k);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, cur_row, act, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
    endtask

    logic        pend;
    logic [31:0] pend_addr;
    logic        fire;
    int          got;

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Reset state
        do_reset();
        @(negedge clk);
        #1;
        chk("rst_req_valid",  32'(imem_req_valid), 32'd0);
        chk("rst_req_addr",   imem_req_addr,       32'h8000_0000);
        chk("rst_inst_valid", 32'(inst_valid),     32'd0);
        chk("rst_inst",       inst,                32'h0);
        chk("rst_inst_pc",    inst_pc,             32'h0);
        chk("rst_busy",       32'(busy),           32'd0);

        //            rst rdy rv rd      ir rdv rpc           hlt | qv qa            iv ins     ipc           bsy
        // sequential fetch, one-cycle response latency
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 1,32'h8000_0000,0,0,     0,            0));
        tbl.push_back(mk(1,1,1,dw(0), 1,0,0,0, 0,32'h8000_0004,0,0,     0,            1));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 1,32'h8000_0004,1,dw(0), 32'h8000_0000,1));
        tbl.push_back(mk(1,1,1,dw(1), 1,0,0,0, 0,32'h8000_0008,0,0,     0,            1));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 1,32'h8000_0008,1,dw(1), 32'h8000_0004,1));
        tbl.push_back(mk(1,1,1,dw(2), 1,0,0,0, 0,32'h8000_000C,0,0,     0,            1));
        // decode stalls: FIFO fills to two, then requests stop
        tbl.push_back(mk(1,1,0,0,     0,0,0,0, 1,32'h8000_000C,1,dw(2), 32'h8000_0008,1));
        tbl.push_back(mk(1,1,1,dw(3), 0,0,0,0, 0,32'h8000_0010,1,dw(2), 32'h8000_0008,1));
        tbl.push_back(mk(1,1,0,0,     0,0,0,0, 0,32'h8000_0010,1,dw(2), 32'h8000_0008,1));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 0,32'h8000_0010,1,dw(2), 32'h8000_0008,1));
        tbl.push_back(mk(1,1,0,0,     0,0,0,0, 1,32'h8000_0010,1,dw(3), 32'h8000_000C,1));
        // redirect while a request is outstanding: its response is dropped
        tbl.push_back(mk(1,1,0,0,     0,1,32'h8000_1000,0, 0,32'h8000_0014,1,dw(3),32'h8000_000C,1));
        tbl.push_back(mk(1,1,1,dw(4), 0,0,0,0, 0,32'h8000_1000,0,0,     0,            1));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 1,32'h8000_1000,0,0,     0,            0));
        tbl.push_back(mk(1,1,1,dw(5), 1,0,0,0, 0,32'h8000_1004,0,0,     0,            1));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 1,32'h8000_1004,1,dw(5), 32'h8000_1000,1));
        // redirect with response in the same cycle, misaligned target
        tbl.push_back(mk(1,1,1,dw(6), 1,1,32'h8000_2003,0, 0,32'h8000_1008,0,0,0,         1));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 1,32'h8000_2000,0,0,     0,            0));
        tbl.push_back(mk(1,1,1,dw(7), 1,0,0,0, 0,32'h8000_2004,0,0,     0,            1));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 1,32'h8000_2004,1,dw(7), 32'h8000_2000,1));
        // halt while waiting: pending word still delivered, then drain
        tbl.push_back(mk(1,1,0,0,     0,0,0,1, 0,32'h8000_2008,0,0,     0,            1));
        tbl.push_back(mk(1,1,1,dw(8), 0,0,0,0, 0,32'h8000_2008,0,0,     0,            1));
        tbl.push_back(mk(1,1,0,0,     0,0,0,0, 0,32'h8000_2008,1,dw(8), 32'h8000_2004,1));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 0,32'h8000_2008,1,dw(8), 32'h8000_2004,1));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 0,32'h8000_2008,0,0,     0,            0));
        // redirect after halt moves pc but issues nothing
        tbl.push_back(mk(1,1,0,0,     1,1,32'h8000_3000,0, 0,32'h8000_2008,0,0,0,         0));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 0,32'h8000_3000,0,0,     0,            0));
        // reset pulse leaves halted state
        tbl.push_back(mk(0,1,0,0,     1,0,0,0, 0,32'h8000_3000,0,0,     0,            0));
        // memory not ready: request held stable, spurious responses ignored
        tbl.push_back(mk(1,0,1,dw(9), 1,0,0,0, 1,32'h8000_0000,0,0,     0,            0));
        tbl.push_back(mk(1,0,0,0,     1,0,0,0, 1,32'h8000_0000,0,0,     0,            0));
        tbl.push_back(mk(1,0,1,dw(9), 1,0,0,0, 1,32'h8000_0000,0,0,     0,            0));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 1,32'h8000_0000,0,0,     0,            0));
        tbl.push_back(mk(1,1,1,dw(10),0,0,0,0, 0,32'h8000_0004,0,0,     0,            1));
        tbl.push_back(mk(1,0,1,dw(11),0,0,0,0, 1,32'h8000_0004,1,dw(10),32'h8000_0000,1));
        tbl.push_back(mk(1,0,0,0,     1,0,0,0, 1,32'h8000_0004,1,dw(10),32'h8000_0000,1));
        // PC wrap at the top of the address space
        tbl.push_back(mk(1,0,0,0,     1,1,32'hFFFF_FFFC,0, 1,32'h8000_0004,0,0,0,         0));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 1,32'hFFFF_FFFC,0,0,     0,            0));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 0,32'h0000_0000,0,0,     0,            1));
        // reset while waiting; late response afterwards is ignored
        tbl.push_back(mk(0,1,0,0,     1,0,0,0, 0,32'h0000_0000,0,0,     0,            1));
        tbl.push_back(mk(1,0,1,dw(12),1,0,0,0, 1,32'h8000_0000,0,0,     0,            0));
        // halt in REQ withdraws the unaccepted request
        tbl.push_back(mk(1,0,0,0,     1,0,0,1, 1,32'h8000_0000,0,0,     0,            0));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 0,32'h8000_0000,0,0,     0,            0));
        tbl.push_back(mk(1,1,1,dw(13),1,0,0,0, 0,32'h8000_0000,0,0,     0,            0));
        tbl.push_back(mk(1,1,0,0,     1,0,0,0, 0,32'h8000_0000,0,0,     0,            0));

        // Table starts from the reset state reached above, with rst_n released.
        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) @(negedge clk);
            cur_row        = i;
            rst_n          = tbl[i].rst_n;
            imem_req_ready = tbl[i].rdy;
            imem_rsp_valid = tbl[i].rv;
            imem_rsp_data  = tbl[i].rd;
            inst_ready     = tbl[i].ir;
            redirect_valid = tbl[i].rdv;
            redirect_pc    = tbl[i].rpc;
            halt           = tbl[i].hlt;
            #1;
            chk("req_valid",  32'(imem_req_valid), 32'(tbl[i].qv));
            chk("req_addr",   imem_req_addr,       tbl[i].qa);
            chk("inst_valid", 32'(inst_valid),     32'(tbl[i].iv));
            chk("inst",       inst,                tbl[i].ins);
            chk("inst_pc",    inst_pc,             tbl[i].ipc);
            chk("busy",       32'(busy),           32'(tbl[i].bsy));
        end

        // Free-running fetch against a one-cycle memory; decode always ready.
        do_reset();
        cur_row   = -2;
        pend      = 1'b0;
        pend_addr = 32'h0;
        got       = 0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(negedge clk);
            rst_n          = 1'b1;
            imem_req_ready = 1'b1;
            inst_ready     = 1'b1;
            imem_rsp_valid = pend;
            imem_rsp_data  = pend_addr ^ 32'h5A5A_5A5A;
            #1;
            if (inst_valid) begin
                chk("seq_inst_pc", inst_pc, 32'h8000_0000 + 32'(4 * got));
                chk("seq_inst",    inst,   (32'h8000_0000 + 32'(4 * got)) ^ 32'h5A5A_5A5A);
                got++;
            end
            fire = imem_req_valid && imem_req_ready;
            if (fire) pend_addr = imem_req_addr;
            @(posedge clk);
            pend = fire;
        end
        chk("seq_delivered", 32'(got), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
